// File: rtl/timers_pkg.sv
// Shared constants for the timer SFR block: SFR addresses, TCON/TMOD bit
// positions and interrupt request vector indices.
package timers_pkg;

    localparam logic [7:0] TCON_ADDR = 8'h88;
    localparam logic [7:0] TMOD_ADDR = 8'h89;
    localparam logic [7:0] TL0_ADDR  = 8'h8A;
    localparam logic [7:0] TH0_ADDR  = 8'h8C;
    localparam logic [7:0] TM0_ADDR  = 8'h8E;

    localparam int TCON_TF0 = 5;
    localparam int TCON_TR0 = 4;
    localparam int TCON_IE0 = 1;
    localparam int TCON_IT0 = 0;

    localparam int TMOD_GATE = 3;
    localparam int TMOD_CT   = 2;
    localparam int TMOD_M1   = 1;
    localparam int TMOD_M0   = 0;

    localparam int IRQ_TF0 = 0;
    localparam int IRQ_IE0 = 1;

endpackage

// File: rtl/timer0_sfr_ctrl_if.sv
// CPU-side SFR bus plus interrupt request/acknowledge handshake
// between the timer0 SFR controller and the core.
interface timer0_sfr_ctrl_if;

    logic [7:0] timers_sfr_addr_i;
    logic       timers_sfr_wr_i;
    logic [7:0] timers_sfr_wdata_i;
    logic       timers_sfr_rd_i;
    logic [7:0] timers_sfr_rdata_o;
    logic [1:0] timers_irq_o;
    logic [1:0] timers_irq_ack_i;

    modport master (
        output timers_sfr_addr_i,
        output timers_sfr_wr_i,
        output timers_sfr_wdata_i,
        output timers_sfr_rd_i,
        output timers_irq_ack_i,
        input  timers_sfr_rdata_o,
        input  timers_irq_o
    );

    modport slave (
        input  timers_sfr_addr_i,
        input  timers_sfr_wr_i,
        input  timers_sfr_wdata_i,
        input  timers_sfr_rd_i,
        input  timers_irq_ack_i,
        output timers_sfr_rdata_o,
        output timers_irq_o
    );

endinterface

// File: rtl/timers_int_sync.sv
// Two-flop synchroniser for an external interrupt pin, plus a delay flop
// that yields a one-cycle pulse on each synchronised falling edge.
module timers_int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic sync_o,
    output logic fall_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic dly_q, dly_d;

    always_comb begin
        s1_d  = pin_i;
        s2_d  = s1_q;
        dly_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            dly_q <= dly_d;
        end
    end

    assign sync_o = s2_q;
    assign fall_o = dly_q & ~s2_q;

endmodule

// File: rtl/timer0_sfr_ctrl.sv
// Timer0 SFR controller: owns TCON/TMOD timer0 bits and count bytes, merges
// timer updates with CPU writes, handles INT0 and IRQs. Option: TIMERS_T0_RD_CAPTURE_EN.
module timer0_sfr_ctrl
    import timers_pkg::*;
(
    input  logic               timers_clock_i,
    input  logic               timers_reset_i_b,
    timer0_sfr_ctrl_if.slave   sfr,
    input  logic               timers_int0_pin_i,
    output logic               timers_t0_int0_o,
    output logic [3:0]         timers_t0_ctrl_o,
    output logic [23:0]        timers_t0_cnt_o,
    output logic               timers_t0_tf0_o,
    input  logic [23:0]        timers_t0_cnt_i,
    input  logic               timers_t0_tf0_i
);

    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  tmod_q, tmod_d;
    logic        tf0_q, tf0_d;
    logic        tr0_q, tr0_d;
    logic        ie0_q, ie0_d;
    logic        it0_q, it0_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  rd_tm0, rd_th0;
    logic        int0_sync, int0_fall;
    logic        wr_tcon, wr_tmod;
    logic [7:0]  wdata;

    timers_int_sync u_int0_sync (
        .clk    (timers_clock_i),
        .rst_n  (timers_reset_i_b),
        .pin_i  (timers_int0_pin_i),
        .sync_o (int0_sync),
        .fall_o (int0_fall)
    );

    assign wdata   = sfr.timers_sfr_wdata_i;
    assign wr_tcon = sfr.timers_sfr_wr_i && (sfr.timers_sfr_addr_i == TCON_ADDR);
    assign wr_tmod = sfr.timers_sfr_wr_i && (sfr.timers_sfr_addr_i == TMOD_ADDR);

`ifdef TIMERS_T0_RD_CAPTURE_EN
    logic [15:0] shadow_q, shadow_d;
    logic        rd_tl0;

    assign rd_tl0 = sfr.timers_sfr_rd_i && (sfr.timers_sfr_addr_i == TL0_ADDR);
    assign rd_tm0 = shadow_q[7:0];
    assign rd_th0 = shadow_q[15:8];

    always_comb begin
        shadow_d = shadow_q;
        if (rd_tl0) shadow_d = cnt_q[23:8];
    end

    always_ff @(posedge timers_clock_i or negedge timers_reset_i_b) begin
        if (!timers_reset_i_b) shadow_q <= '0;
        else                   shadow_q <= shadow_d;
    end
`else
    assign rd_tm0 = cnt_q[15:8];
    assign rd_th0 = cnt_q[23:16];
`endif

    always_comb begin
        cnt_d  = timers_t0_cnt_i;
        tmod_d = tmod_q;
        tr0_d  = tr0_q;
        it0_d  = it0_q;
        if (sfr.timers_sfr_wr_i) begin
            case (sfr.timers_sfr_addr_i)
                TL0_ADDR: cnt_d[7:0]   = wdata;
                TM0_ADDR: cnt_d[15:8]  = wdata;
                TH0_ADDR: cnt_d[23:16] = wdata;
                default:  ;
            endcase
        end
        if (wr_tmod) tmod_d = wdata[3:0];
        if (wr_tcon) begin
            tr0_d = wdata[TCON_TR0];
            it0_d = wdata[TCON_IT0];
        end
    end

    // A fresh overflow or INT0 edge outranks writes and acks so no event is lost
    always_comb begin
        if (timers_t0_tf0_i && !tf0_q)     tf0_d = 1'b1;
        else if (wr_tcon)                  tf0_d = wdata[TCON_TF0];
        else if (sfr.timers_irq_ack_i[IRQ_TF0]) tf0_d = 1'b0;
        else                               tf0_d = timers_t0_tf0_i;

        ie0_d = ie0_q;
        if (it0_q) begin
            if (int0_fall)                          ie0_d = 1'b1;
            else if (wr_tcon)                       ie0_d = wdata[TCON_IE0];
            else if (sfr.timers_irq_ack_i[IRQ_IE0]) ie0_d = 1'b0;
        end else begin
            ie0_d = ~int0_sync;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (sfr.timers_sfr_rd_i) begin
            case (sfr.timers_sfr_addr_i)
                TCON_ADDR: rdata_d = {2'b00, tf0_q, tr0_q, 2'b00, ie0_q, it0_q};
                TMOD_ADDR: rdata_d = {4'h0, tmod_q};
                TL0_ADDR:  rdata_d = cnt_q[7:0];
                TM0_ADDR:  rdata_d = rd_tm0;
                TH0_ADDR:  rdata_d = rd_th0;
                default:   rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge timers_clock_i or negedge timers_reset_i_b) begin
        if (!timers_reset_i_b) begin
            cnt_q   <= '0;
            tmod_q  <= '0;
            tf0_q   <= 1'b0;
            tr0_q   <= 1'b0;
            ie0_q   <= 1'b0;
            it0_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tmod_q  <= tmod_d;
            tf0_q   <= tf0_d;
            tr0_q   <= tr0_d;
            ie0_q   <= ie0_d;
            it0_q   <= it0_d;
            rdata_q <= rdata_d;
        end
    end

    assign timers_t0_int0_o   = int0_sync;
    assign timers_t0_ctrl_o   = {tmod_q[TMOD_GATE], tmod_q[TMOD_M1], tmod_q[TMOD_M0], tr0_q};
    assign timers_t0_cnt_o    = cnt_q;
    assign timers_t0_tf0_o    = tf0_q;
    assign sfr.timers_sfr_rdata_o = rdata_q;
    assign sfr.timers_irq_o   = {ie0_q, tf0_q};

endmodule

// File: tb/tb_timer0_sfr_ctrl.sv
// Directed and randomized bench for timer0_sfr_ctrl against a behavioural
// model of the SFR rules (count merge, TF0/IE0 priority, INT0 latency, reads).
module tb_timer0_sfr_ctrl;

    localparam logic [7:0] A_TCON = 8'h88;
    localparam logic [7:0] A_TMOD = 8'h89;
    localparam logic [7:0] A_TL0  = 8'h8A;
    localparam logic [7:0] A_TH0  = 8'h8C;
    localparam logic [7:0] A_TM0  = 8'h8E;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pin;
    logic        int0_o;
    logic [3:0]  ctrl_o;
    logic [23:0] cnt_o;
    logic        tf0_o;
    logic [23:0] cnt_i;
    logic        tf0_i;

    int checks = 0;
    int failures = 0;

    timer0_sfr_ctrl_if bus ();

    timer0_sfr_ctrl dut (
        .timers_clock_i   (clk),
        .timers_reset_i_b (rst_n),
        .sfr              (bus.slave),
        .timers_int0_pin_i(pin),
        .timers_t0_int0_o (int0_o),
        .timers_t0_ctrl_o (ctrl_o),
        .timers_t0_cnt_o  (cnt_o),
        .timers_t0_tf0_o  (tf0_o),
        .timers_t0_cnt_i  (cnt_i),
        .timers_t0_tf0_i  (tf0_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers updated per clock from the rules
    logic [23:0] m_cnt;
    logic [3:0]  m_tmod;
    logic        m_tf0, m_tr0, m_ie0, m_it0;
    logic [7:0]  m_rdata;
    logic [15:0] m_shadow;
    bit          pin_hist[3];

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            A_TCON: return {2'b00, m_tf0, m_tr0, 2'b00, m_ie0, m_it0};
            A_TMOD: return {4'h0, m_tmod};
            A_TL0:  return m_cnt[7:0];
`ifdef TIMERS_T0_RD_CAPTURE_EN
            A_TM0:  return m_shadow[7:0];
            A_TH0:  return m_shadow[15:8];
`else
            A_TM0:  return m_cnt[15:8];
            A_TH0:  return m_cnt[23:16];
`endif
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = '0; m_tmod = '0; m_tf0 = 0; m_tr0 = 0;
            m_ie0 = 0; m_it0 = 0; m_rdata = '0; m_shadow = '0;
            pin_hist[0] = 0; pin_hist[1] = 0; pin_hist[2] = 0;
        end else begin
            logic [23:0] nc;
            logic nt, ni, wt, sync_now, fell;
            wt = bus.timers_sfr_wr_i && bus.timers_sfr_addr_i == A_TCON;
            sync_now = pin_hist[1];
            fell = pin_hist[2] && !pin_hist[1];
            nc = cnt_i;
            if (bus.timers_sfr_wr_i) begin
                if (bus.timers_sfr_addr_i == A_TL0) nc[7:0]   = bus.timers_sfr_wdata_i;
                if (bus.timers_sfr_addr_i == A_TM0) nc[15:8]  = bus.timers_sfr_wdata_i;
                if (bus.timers_sfr_addr_i == A_TH0) nc[23:16] = bus.timers_sfr_wdata_i;
            end
            if (tf0_i && !m_tf0) nt = 1;
            else if (wt) nt = bus.timers_sfr_wdata_i[5];
            else if (bus.timers_irq_ack_i[0]) nt = 0;
            else nt = tf0_i;
            ni = m_ie0;
            if (m_it0) begin
                if (fell) ni = 1;
                else if (wt) ni = bus.timers_sfr_wdata_i[1];
                else if (bus.timers_irq_ack_i[1]) ni = 0;
            end else ni = !sync_now;
            if (bus.timers_sfr_rd_i) begin
                m_rdata = m_read(bus.timers_sfr_addr_i);
                if (bus.timers_sfr_addr_i == A_TL0) m_shadow = m_cnt[23:8];
            end
            if (wt) begin
                m_tr0 = bus.timers_sfr_wdata_i[4];
                m_it0 = bus.timers_sfr_wdata_i[0];
            end
            if (bus.timers_sfr_wr_i && bus.timers_sfr_addr_i == A_TMOD)
                m_tmod = bus.timers_sfr_wdata_i[3:0];
            m_cnt = nc; m_tf0 = nt; m_ie0 = ni;
            pin_hist[2] = pin_hist[1];
            pin_hist[1] = pin_hist[0];
            pin_hist[0] = pin;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
        bus.timers_sfr_wr_i = 1; bus.timers_sfr_addr_i = a;
        bus.timers_sfr_wdata_i = d;
        tick();
        bus.timers_sfr_wr_i = 0;
    endtask

    task automatic sfr_rd(input logic [7:0] a);
        bus.timers_sfr_rd_i = 1; bus.timers_sfr_addr_i = a;
        tick();
        bus.timers_sfr_rd_i = 0;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_cnt"},   cnt_o, m_cnt);
        chk({tag, "_ctrl"},  ctrl_o, {m_tmod[3], m_tmod[1], m_tmod[0], m_tr0});
        chk({tag, "_tf0"},   tf0_o, m_tf0);
        chk({tag, "_irq"},   bus.timers_irq_o, {m_ie0, m_tf0});
        chk({tag, "_int0"},  int0_o, pin_hist[1]);
        chk({tag, "_rdata"}, bus.timers_sfr_rdata_o, m_rdata);
    endtask

    initial begin
        logic [7:0] addrs[6];
        addrs = '{A_TCON, A_TMOD, A_TL0, A_TH0, A_TM0, 8'h00};
        pin = 1; cnt_i = '0; tf0_i = 0;
        bus.timers_sfr_addr_i = '0; bus.timers_sfr_wr_i = 0;
        bus.timers_sfr_wdata_i = '0; bus.timers_sfr_rd_i = 0;
        bus.timers_irq_ack_i = '0;
        tick(); tick();
        chk("rst_cnt", cnt_o, 24'h0);
        chk("rst_irq", bus.timers_irq_o, 2'b00);
        chk("rst_int0", int0_o, 1'b0);
        rst_n = 1;
        repeat (3) tick();

        sfr_wr(A_TMOD, 8'h03);
        sfr_wr(A_TCON, 8'h10);
        chk("ctrl_0111", ctrl_o, 4'b0111);
        sfr_rd(A_TMOD);
        chk("rd_tmod", bus.timers_sfr_rdata_o, 8'h03);

        sfr_wr(A_TH0, 8'hFF);
        chk("wr_th0", cnt_o, 24'hFF0000);
        tf0_i = 1; tick();
        chk("ovf_irq", bus.timers_irq_o, 2'b01);
        tick();
        chk("tf0_echo", tf0_o, 1'b1);
        tf0_i = 0; bus.timers_irq_ack_i = 2'b01; tick();
        chk("ack_clr", bus.timers_irq_o, 2'b00);
        tf0_i = 1; tick();
        bus.timers_irq_ack_i = 2'b00;
        chk("ovf_beats_ack", bus.timers_irq_o, 2'b01);
        tf0_i = 0; bus.timers_irq_ack_i = 2'b01; tick();
        bus.timers_irq_ack_i = 2'b00;

        sfr_wr(A_TCON, 8'h11);
        pin = 0; tick();
        tick();
        chk("int0_sync", int0_o, 1'b0);
        chk("ie0_k2", bus.timers_irq_o[1], 1'b0);
        tick();
        chk("ie0_k3", bus.timers_irq_o[1], 1'b1);
        bus.timers_irq_ack_i = 2'b10; tick();
        bus.timers_irq_ack_i = 2'b00;
        chk("ie0_ack", bus.timers_irq_o[1], 1'b0);
        tick();
        chk("ie0_low_hold", bus.timers_irq_o[1], 1'b0);
        sfr_wr(A_TCON, 8'h10);
        tick();
        chk("ie0_level", bus.timers_irq_o[1], 1'b1);
        bus.timers_irq_ack_i = 2'b10; tick();
        bus.timers_irq_ack_i = 2'b00;
        chk("ie0_level_ack", bus.timers_irq_o[1], 1'b1);
        pin = 1;

        cnt_i = 24'h123456;
        sfr_wr(A_TM0, 8'hAA);
        chk("merge_tm0", cnt_o, 24'h12AA56);

        cnt_i = 24'h0100FF; tick();
        cnt_i = 24'h010100;
        sfr_rd(A_TL0);
        chk("rd_tl0", bus.timers_sfr_rdata_o, 8'hFF);
        sfr_rd(A_TM0);
`ifdef TIMERS_T0_RD_CAPTURE_EN
        chk("rd_tm0", bus.timers_sfr_rdata_o, 8'h00);
`else
        chk("rd_tm0", bus.timers_sfr_rdata_o, 8'h01);
`endif
        sfr_rd(A_TH0);
        chk("rd_th0", bus.timers_sfr_rdata_o, 8'h01);
        cmp_model("dir");

        tf0_i = 1;
        sfr_wr(A_TCON, 8'h30);
        chk("pre_rst_irq", bus.timers_irq_o, 2'b01);
        chk("pre_rst_tr0", ctrl_o[0], 1'b1);
        #2 rst_n = 0;
        #1;
        chk("arst_ctrl", ctrl_o, 4'h0);
        chk("arst_cnt", cnt_o, 24'h0);
        chk("arst_irq", bus.timers_irq_o, 2'b00);
        chk("arst_tf0", tf0_o, 1'b0);
        chk("arst_rdata", bus.timers_sfr_rdata_o, 8'h00);
        chk("arst_int0", int0_o, 1'b0);
        tick();
        rst_n = 1; tf0_i = 0;

        for (int i = 0; i < 3000; i++) begin
            tick();
            cmp_model("rnd");
            bus.timers_sfr_addr_i = addrs[$urandom_range(0, 5)];
            if (bus.timers_sfr_addr_i == 8'h00)
                bus.timers_sfr_addr_i = 8'($urandom);
            bus.timers_sfr_wr_i = ($urandom_range(0, 3) == 0);
            bus.timers_sfr_rd_i = $urandom_range(0, 1);
            bus.timers_sfr_wdata_i = 8'($urandom);
            bus.timers_irq_ack_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            cnt_i = 24'($urandom);
            tf0_i = m_tf0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) pin = ~pin;
        end
        tick();
        cmp_model("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
